// File: rtl/ghoul_pkg.sv
// Shared types and constants for the ghoul wave scheduler: FSM states,
// LFSR seed/taps and spawn-area geometry.
package ghoul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAVE_INTRO,
      ST_SPAWN,
      ST_FIGHT,
      ST_DONE
   } state_t;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [9:0] SPAWN_X_BASE = 10'd32;
   localparam logic [8:0] SPAWN_Y_BASE = 9'd48;
   localparam logic [9:0] SCREEN_X_MAX = 10'd639;
   localparam logic [8:0] SCREEN_Y_MAX = 9'd479;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

   // Spawn X from 9 random bits; clamp keeps the point on screen
   function automatic logic [9:0] spawn_x_of(input logic [8:0] r);
      logic [9:0] x;
      x = SPAWN_X_BASE + {1'b0, r};
      return (x > SCREEN_X_MAX) ? SCREEN_X_MAX : x;
   endfunction

   // Spawn Y from 7 random bits (48..175); clamp keeps the point on screen
   function automatic logic [8:0] spawn_y_of(input logic [6:0] r);
      logic [8:0] y;
      y = SPAWN_Y_BASE + {2'b00, r};
      return (y > SCREEN_Y_MAX) ? SCREEN_Y_MAX : y;
   endfunction

endpackage

// File: rtl/ghoul_lfsr16.sv
// Free-running 16-bit pseudo-random source; steps once per enable pulse.
module ghoul_lfsr16
   import ghoul_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] value
);

   logic [15:0] lfsr_q, lfsr_d;

   // Next value: shift only when enabled
   always_comb begin
      lfsr_d = lfsr_q;
      if (en) lfsr_d = lfsr_next(lfsr_q);
   end

   // LFSR register, seeded on reset so it never holds zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign value = lfsr_q;

endmodule

// File: rtl/ghoul_wave_sched.sv
// Ghoul wave scheduler: sequences intro/spawn/fight per wave, allocates the
// lowest free ghoul slot for each spawn and tracks occupancy from kills.
module ghoul_wave_sched
   import ghoul_pkg::*;
#(
   parameter  int unsigned NUM_GHOULS = 3,
   parameter  int unsigned SPAWN_GAP  = 60,
   parameter  int unsigned WAVE_PAUSE = 120,
   parameter  int unsigned MAX_WAVE   = 7,
   parameter  int unsigned GHOUL_HP   = 3,
   localparam int unsigned IDX_W      = (NUM_GHOULS > 1) ? $clog2(NUM_GHOULS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic                  start,
   input  logic                  kill_valid,
   input  logic [IDX_W-1:0]      kill_idx,
   output logic                  spawn_valid,
   input  logic                  spawn_ready,
   output logic [IDX_W-1:0]      spawn_idx,
   output logic [9:0]            spawn_x,
   output logic [8:0]            spawn_y,
   output logic [1:0]            spawn_hp,
   output logic [NUM_GHOULS-1:0] slot_active,
   output logic [2:0]            wave_num,
   output logic [3:0]            move_div,
   output logic                  game_won
);

   localparam int unsigned PW = $clog2(WAVE_PAUSE + 1);
   localparam int unsigned GW = $clog2(SPAWN_GAP + 1);

   localparam logic [PW-1:0]  PAUSE_LOAD = PW'(WAVE_PAUSE);
   localparam logic [GW-1:0]  GAP_LOAD   = GW'(SPAWN_GAP);
   localparam logic [2:0]     LAST_WAVE  = 3'(MAX_WAVE);
   localparam logic [1:0]     HP_LOAD    = 2'(GHOUL_HP);
   localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W + 1)'(NUM_GHOULS);

   state_t                  state_q, state_d;
   logic                    valid_q, valid_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [9:0]              x_q, x_d;
   logic [8:0]              y_q, y_d;
   logic [1:0]              hp_q, hp_d;
   logic [NUM_GHOULS-1:0]   slot_q, slot_d;
   logic [2:0]              wave_q, wave_d;
   logic                    won_q, won_d;
   logic [PW-1:0]           pause_q, pause_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic [3:0]              spawned_q, spawned_d;

   logic [15:0]             lfsr;
   logic [IDX_W-1:0]        free_idx;
   logic                    any_free;
   logic [3:0]              quota;
   logic                    xfer;
   logic                    kill_ok;

   ghoul_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (frame_tick),
      .value (lfsr)
   );

   // Lowest-index free slot
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int unsigned i = 0; i < NUM_GHOULS; i++) begin
         if (!slot_q[i] && !any_free) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Next-state logic: counters, occupancy, spawn handshake and wave FSM
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      x_d       = x_q;
      y_d       = y_q;
      hp_d      = hp_q;
      slot_d    = slot_q;
      wave_d    = wave_q;
      won_d     = won_q;
      pause_d   = pause_q;
      gap_d     = gap_q;
      spawned_d = spawned_q;

      quota   = {1'b0, wave_q} + 4'd2;
      xfer    = valid_q && spawn_ready;
      kill_ok = kill_valid && ({1'b0, kill_idx} < SLOT_LIMIT);

      if (frame_tick && (gap_q != '0)) gap_d = gap_q - GW'(1);

      // Kill is applied before the transfer set; they never hit the same
      // slot because the pending spawn slot is still inactive.
      if (kill_ok) slot_d[kill_idx] = 1'b0;

      if (xfer) begin
         slot_d[idx_q] = 1'b1;
         valid_d       = 1'b0;
         spawned_d     = spawned_q + 4'd1;
         gap_d         = GAP_LOAD;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_WAVE_INTRO;
               wave_d  = 3'd1;
               won_d   = 1'b0;
               slot_d  = '0;
               pause_d = PAUSE_LOAD;
            end
         end
         ST_WAVE_INTRO: begin
            if (frame_tick) begin
               if (pause_q <= PW'(1)) begin
                  state_d   = ST_SPAWN;
                  pause_d   = '0;
                  spawned_d = '0;
                  gap_d     = '0;
               end else begin
                  pause_d = pause_q - PW'(1);
               end
            end
         end
         ST_SPAWN: begin
            if ((spawned_q == quota) && !valid_q) begin
               state_d = ST_FIGHT;
            end else if (!valid_q && (gap_q == '0) && (spawned_q < quota) && any_free) begin
               valid_d = 1'b1;
               idx_d   = free_idx;
               x_d     = spawn_x_of(lfsr[8:0]);
               y_d     = spawn_y_of(lfsr[15:9]);
               hp_d    = HP_LOAD;
            end
         end
         ST_FIGHT: begin
            if (slot_q == '0) begin
               if (wave_q < LAST_WAVE) begin
                  wave_d  = wave_q + 3'd1;
                  pause_d = PAUSE_LOAD;
                  state_d = ST_WAVE_INTRO;
               end else begin
                  state_d = ST_DONE;
                  won_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         hp_q      <= '0;
         slot_q    <= '0;
         wave_q    <= '0;
         won_q     <= 1'b0;
         pause_q   <= '0;
         gap_q     <= '0;
         spawned_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         x_q       <= x_d;
         y_q       <= y_d;
         hp_q      <= hp_d;
         slot_q    <= slot_d;
         wave_q    <= wave_d;
         won_q     <= won_d;
         pause_q   <= pause_d;
         gap_q     <= gap_d;
         spawned_q <= spawned_d;
      end
   end

   // Movement divider speeds ghouls up as waves progress
   always_comb begin
      move_div = 4'd8;
      if (wave_q != 3'd0) move_div = 4'd8 - {1'b0, wave_q};
   end

   assign spawn_valid = valid_q;
   assign spawn_idx   = idx_q;
   assign spawn_x     = x_q;
   assign spawn_y     = y_q;
   assign spawn_hp    = hp_q;
   assign slot_active = slot_q;
   assign wave_num    = wave_q;
   assign game_won    = won_q;

endmodule

// File: tb/tb_ghoul_wave_sched.sv
// Directed bench for ghoul_wave_sched with a spawn-slot scoreboard and an
// independent LFSR model for spawn coordinates.
module tb_ghoul_wave_sched;
   import ghoul_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       kill_valid = 1'b0;
   logic [1:0] kill_idx = 2'd0;
   logic       spawn_ready = 1'b1;
   logic       spawn_valid;
   logic [1:0] spawn_idx;
   logic [9:0] spawn_x;
   logic [8:0] spawn_y;
   logic [1:0] spawn_hp;
   logic [2:0] slot_active;
   logic [2:0] wave_num;
   logic [3:0] move_div;
   logic       game_won;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_n = 0;
   int ticks_seen = 0;
   int exp_q[$];
   int xfer_tick[$];

   always #5 clk = ~clk;

   ghoul_wave_sched #(
      .NUM_GHOULS (3),
      .SPAWN_GAP  (2),
      .WAVE_PAUSE (3),
      .MAX_WAVE   (2),
      .GHOUL_HP   (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start       (start),
      .kill_valid  (kill_valid),
      .kill_idx    (kill_idx),
      .spawn_valid (spawn_valid),
      .spawn_ready (spawn_ready),
      .spawn_idx   (spawn_idx),
      .spawn_x     (spawn_x),
      .spawn_y     (spawn_y),
      .spawn_hp    (spawn_hp),
      .slot_active (slot_active),
      .wave_num    (wave_num),
      .move_div    (move_div),
      .game_won    (game_won)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference LFSR (x^16+x^14+x^13+x^11+1); m_prev is the value the DUT saw
   // at the most recent edge.
   logic [15:0] m_lfsr, m_prev;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_lfsr <= 16'hACE1;
         m_prev <= 16'hACE1;
      end else begin
         m_prev <= m_lfsr;
         if (frame_tick) m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
   end

   always @(posedge clk) begin
      if (!reset && frame_tick) ticks_seen++;
   end

   // Spawn monitor: payload vs model while pending, slot vs scoreboard, pop on transfer
   logic       pv = 1'b0;
   logic [9:0] ex = '0;
   logic [8:0] ey = '0;
   always @(negedge clk) begin
      if (reset) begin
         pv = 1'b0;
      end else begin
         if (spawn_valid) begin
            if (!pv) begin
               ex = 10'd32 + {1'b0, m_prev[8:0]};
               ey = 9'd48 + {2'b00, m_prev[15:9]};
               chk("spawn_hp", 32'(spawn_hp), 3);
               chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            end
            chk("spawn_x", 32'(spawn_x), 32'(ex));
            chk("spawn_y", 32'(spawn_y), 32'(ey));
            if (exp_q.size() != 0) chk("spawn_idx", 32'(spawn_idx), exp_q[0]);
            if (spawn_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               xfer_tick.push_back(ticks_seen);
            end
         end
         pv = spawn_valid;
      end
   end

   // One clock; a frame tick on every fourth cycle
   task automatic adv();
      frame_tick = (cyc_n % 4 == 0);
      cyc_n++;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic wait_state(input state_t st, input int budget, input string tag);
      int n = 0;
      while (dut.state_q !== st && n < budget) begin adv(); n++; end
      chk(tag, 32'(dut.state_q), 32'(st));
   endtask

   task automatic wait_slots(input logic [2:0] val, input int budget, input string tag);
      int n = 0;
      while (slot_active !== val && n < budget) begin adv(); n++; end
      chk(tag, 32'(slot_active), 32'(val));
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      while (spawn_valid !== 1'b1 && n < budget) begin adv(); n++; end
      chk(tag, 32'(spawn_valid), 1);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_valid"}, 32'(spawn_valid), 0);
      chk({p, "_idx"},   32'(spawn_idx), 0);
      chk({p, "_x"},     32'(spawn_x), 0);
      chk({p, "_y"},     32'(spawn_y), 0);
      chk({p, "_hp"},    32'(spawn_hp), 0);
      chk({p, "_slots"}, 32'(slot_active), 0);
      chk({p, "_wave"},  32'(wave_num), 0);
      chk({p, "_div"},   32'(move_div), 8);
      chk({p, "_won"},   32'(game_won), 0);
      chk({p, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
   endtask

   task automatic kill_slot(input int k);
      kill_valid = 1'b1;
      kill_idx   = 2'(k);
      adv();
      kill_valid = 1'b0;
   endtask

   initial begin
      int t0;
      int seen;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      reset = 1'b0;

      // Game 1, wave 1
      start = 1'b1; adv(); start = 1'b0;
      chk("start_wave", 32'(wave_num), 1);
      chk("start_state", 32'(dut.state_q), 32'(ST_WAVE_INTRO));
      chk("wave1_div", 32'(move_div), 7);
      t0 = ticks_seen;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      wait_valid(40, "first_spawn");
      chk("intro_ticks", 32'(ticks_seen - t0), 3);
      chk("first_idx", 32'(spawn_idx), 0);
      wait_state(ST_FIGHT, 80, "wave1_fight");
      chk("wave1_slots", 32'(slot_active), 3'b111);
      chk("wave1_sb_empty", 32'(exp_q.size()), 0);
      chk("wave1_xfers", 32'(xfer_tick.size()), 3);
      if (xfer_tick.size() >= 3) begin
         chk("gap_ticks_1", 32'(xfer_tick[1] - xfer_tick[0]), 2);
         chk("gap_ticks_2", 32'(xfer_tick[2] - xfer_tick[1]), 2);
      end
      for (int k = 0; k < 3; k++) kill_slot(k);
      adv();
      chk("wave2_num", 32'(wave_num), 2);
      chk("wave2_div", 32'(move_div), 6);
      chk("wave2_state", 32'(dut.state_q), 32'(ST_WAVE_INTRO));

      // Wave 2: slots fill, fourth spawn blocked until a kill
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      wait_slots(3'b111, 80, "wave2_fill");
      seen = 0;
      repeat (12) begin adv(); if (spawn_valid) seen = 1; end
      chk("full_no_spawn", 32'(seen), 0);
      chk("full_state", 32'(dut.state_q), 32'(ST_SPAWN));
      spawn_ready = 1'b0;
      exp_q.push_back(1);
      kill_slot(1);
      chk("kill1_slots", 32'(slot_active), 3'b101);
      wait_valid(20, "refill_spawn");
      chk("refill_idx", 32'(spawn_idx), 1);
      repeat (5) begin
         adv();
         chk("hold_valid", 32'(spawn_valid), 1);
         chk("hold_slots", 32'(slot_active), 3'b101);
      end
      spawn_ready = 1'b1;
      adv();
      chk("ready_xfer_slots", 32'(slot_active), 3'b111);
      chk("ready_xfer_valid", 32'(spawn_valid), 0);
      wait_state(ST_FIGHT, 20, "wave2_fight");
      for (int k = 0; k < 3; k++) kill_slot(k);
      adv();
      chk("done_state", 32'(dut.state_q), 32'(ST_DONE));
      chk("done_won", 32'(game_won), 1);
      chk("done_wave", 32'(wave_num), 2);

      // Game 2: restart from DONE
      start = 1'b1; adv(); start = 1'b0;
      chk("restart_won", 32'(game_won), 0);
      chk("restart_wave", 32'(wave_num), 1);
      chk("restart_state", 32'(dut.state_q), 32'(ST_WAVE_INTRO));
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      wait_slots(3'b011, 80, "g2_two_slots");
      spawn_ready = 1'b0;
      wait_valid(20, "g2_third_spawn");
      chk("g2_third_idx", 32'(spawn_idx), 2);
      kill_valid = 1'b1; kill_idx = 2'd0; spawn_ready = 1'b1;
      adv();
      kill_valid = 1'b0;
      chk("kill_and_xfer", 32'(slot_active), 3'b110);
      kill_slot(0);
      chk("kill_inactive", 32'(slot_active), 3'b110);
      kill_slot(3);
      chk("kill_out_of_range", 32'(slot_active), 3'b110);
      kill_slot(1);
      kill_slot(2);
      adv();
      chk("g2_wave2", 32'(wave_num), 2);

      // Reset while a spawn is pending
      spawn_ready = 1'b0;
      exp_q.push_back(0);
      wait_valid(40, "pre_reset_spawn");
      chk("pre_reset_state", 32'(dut.state_q), 32'(ST_SPAWN));
      reset = 1'b1;
      #1;
      chk_reset("midrst");
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      adv(); adv();
      chk("post_reset_state", 32'(dut.state_q), 32'(ST_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
